// File: rtl/apb_request_arbiter.sv
// apb_request_arbiter: round-robin arbiter sequencing NO_REQ requesters onto one APB_Master command port
module apb_request_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NO_SLAVES = 2,
    parameter int NO_REQ = 4,
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic                             pclk,
    input  logic                             preset_n,
    input  logic [NO_REQ-1:0]                req_valid,
    input  logic [NO_REQ*ADDR_WIDTH-1:0]     req_address,
    input  logic [NO_REQ*3-1:0]              req_protection,
    input  logic [NO_REQ*NO_SLAVES-1:0]      req_select,
    input  logic [NO_REQ-1:0]                req_read_write,
    input  logic [NO_REQ*DATA_WIDTH-1:0]     req_write_data,
    input  logic [NO_REQ*BYTES_PER_WORD-1:0] req_strobe,
    output logic [NO_REQ-1:0]                req_ready,
    output logic [NO_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_read_data,
    output logic                             rsp_error,
    output logic                             master_transfer,
    output logic [ADDR_WIDTH-1:0]            master_address,
    output logic [2:0]                       master_protection,
    output logic [NO_SLAVES-1:0]             master_select,
    output logic                             master_read_write,
    output logic [DATA_WIDTH-1:0]            master_write_data,
    output logic [BYTES_PER_WORD-1:0]        master_strobe,
    input  logic [DATA_WIDTH-1:0]            slave_read_data,
    input  logic                             slave_error,
    input  logic                             slave_data_ready,
    output logic                             busy
);
    localparam int LW = $clog2(NO_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                    state_q, state_d;
    logic [LW-1:0]             owner_q, owner_d, last_grant_q, last_grant_d, win;
    logic                      found;
    int                        idx;
    logic [NO_REQ-1:0]         req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_read_data_q, rsp_read_data_d;
    logic                      rsp_error_q, rsp_error_d, transfer_q, transfer_d;
    logic [ADDR_WIDTH-1:0]     address_q, address_d;
    logic [2:0]                protection_q, protection_d;
    logic [NO_SLAVES-1:0]      select_q, select_d;
    logic                      read_write_q, read_write_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
    logic [BYTES_PER_WORD-1:0] strobe_q, strobe_d;
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= NO_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NO_REQ) idx = idx - NO_REQ;
            if (!found && req_valid[LW'(idx)]) begin
                win = LW'(idx);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_grant_d = last_grant_q;
        address_d = address_q;
        protection_d = protection_q;
        select_d = select_q;
        read_write_d = read_write_q;
        write_data_d = write_data_q;
        strobe_d = strobe_q;
        rsp_read_data_d = rsp_read_data_q;
        rsp_error_d = rsp_error_q;
        transfer_d = 1'b0;
        req_ready_d = '0;
        rsp_valid_d = '0;
        if (state_q == IDLE && found) begin
            state_d = ISSUE;
            owner_d = win;
            last_grant_d = win;
            address_d = req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            protection_d = req_protection[int'(win)*3 +: 3];
            select_d = req_select[int'(win)*NO_SLAVES +: NO_SLAVES];
            read_write_d = req_read_write[win];
            write_data_d = req_write_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            strobe_d = req_strobe[int'(win)*BYTES_PER_WORD +: BYTES_PER_WORD];
            transfer_d = 1'b1;
            req_ready_d = NO_REQ'(1) << win;
        end else if (state_q == ISSUE) begin
            state_d = WAIT;
        end else if (state_q == WAIT && slave_data_ready) begin
            state_d = IDLE;
            rsp_valid_d[owner_q] = 1'b1;
            rsp_read_data_d = slave_read_data;
            rsp_error_d = slave_error;
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_grant_q <= LW'(NO_REQ - 1);
            address_q <= '0;
            protection_q <= '0;
            select_q <= '0;
            read_write_q <= 1'b0;
            write_data_q <= '0;
            strobe_q <= '0;
            rsp_read_data_q <= '0;
            rsp_error_q <= 1'b0;
            transfer_q <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_grant_q <= last_grant_d;
            address_q <= address_d;
            protection_q <= protection_d;
            select_q <= select_d;
            read_write_q <= read_write_d;
            write_data_q <= write_data_d;
            strobe_q <= strobe_d;
            rsp_read_data_q <= rsp_read_data_d;
            rsp_error_q <= rsp_error_d;
            transfer_q <= transfer_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q <= busy_d;
        end
    end
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_read_data = rsp_read_data_q;
    assign rsp_error = rsp_error_q;
    assign master_transfer = transfer_q;
    assign master_address = address_q;
    assign master_protection = protection_q;
    assign master_select = select_q;
    assign master_read_write = read_write_q;
    assign master_write_data = write_data_q;
    assign master_strobe = strobe_q;
    assign busy = busy_q;
endmodule
